// File: rtl/fpu_types.sv
// rtl/fpu_types.sv - shared FP writeback types, constants and the sticky-flag merge helper
package fpu_types;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    localparam int FP_NUM_WB_UNITS = 4;
    localparam int FP_FLEN         = 64;
    localparam int FP_ID_WIDTH     = 3;

    typedef struct packed {
        logic [FP_ID_WIDTH-1:0] id;
        logic [FP_FLEN-1:0]     data;
    } wb_pkt_t;

    // A CSR write replaces the sticky value, but a retiring result's flags are always OR-ed on top.
    function automatic fflags_t fflags_merge(input fflags_t acc, input logic csr_we,
                                             input fflags_t csr_wdata, input logic grant,
                                             input fflags_t unit_flags);
        fflags_t base;
        base = csr_we ? csr_wdata : acc;
        return grant ? (base | unit_flags) : base;
    endfunction

endpackage

// File: rtl/fp_rr_arbiter.sv
// rtl/fp_rr_arbiter.sv - combinational round-robin grant with its rotating pointer register
module fp_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW-1:0] ptr;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!grant_valid && !rst && req[(int'(ptr) + k) % N]) begin
                grant[(int'(ptr) + k) % N] = 1'b1;
                grant_idx   = IW'((int'(ptr) + k) % N);
                grant_valid = 1'b1;
            end
        end
    end

    // The writeback port never stalls, so every grant is consumed and advances the pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/fp_wb_arbiter.sv
// rtl/fp_wb_arbiter.sv - FP writeback arbiter and sticky fflags; FP_WB_OUTPUT_REG_EN registers the writeback port
module fp_wb_arbiter
    import fpu_types::*;
#(
    parameter int NUM_UNITS = FP_NUM_WB_UNITS,
    parameter int FLEN      = FP_FLEN,
    parameter int ID_WIDTH  = FP_ID_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_UNITS-1:0]                unit_done,
    input  logic [NUM_UNITS-1:0][ID_WIDTH-1:0]  unit_id,
    input  logic [NUM_UNITS-1:0][FLEN-1:0]      unit_rd,
    input  logic [NUM_UNITS-1:0][4:0]           unit_fflags,
    output logic [NUM_UNITS-1:0]                unit_ack,
    output logic                                wb_valid,
    output logic [ID_WIDTH-1:0]                 wb_id,
    output logic [FLEN-1:0]                     wb_data,
    input  logic                                csr_fflags_we,
    input  logic [4:0]                          csr_fflags_wdata,
    output logic [4:0]                          fflags_acc
);

    localparam int IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [IW-1:0]       grant_idx;
    logic                grant_valid;
    logic [ID_WIDTH-1:0] sel_id;
    logic [FLEN-1:0]     sel_data;
    fflags_t             sel_flags;
    fflags_t             acc_q;

    fp_rr_arbiter #(.N(NUM_UNITS), .IW(IW)) u_rr (
        .clk         (clk),
        .rst         (rst),
        .req         (unit_done),
        .grant       (unit_ack),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel_id    = '0;
        sel_data  = '0;
        sel_flags = '0;
        if (grant_valid) begin
            sel_id    = unit_id[grant_idx];
            sel_data  = unit_rd[grant_idx];
            sel_flags = unit_fflags[grant_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= fflags_merge(acc_q, csr_fflags_we, csr_fflags_wdata, grant_valid, sel_flags);
        end
    end

    assign fflags_acc = acc_q;

`ifdef FP_WB_OUTPUT_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_id    <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= grant_valid;
            wb_id    <= sel_id;
            wb_data  <= sel_data;
        end
    end
`else
    assign wb_valid = grant_valid;
    assign wb_id    = sel_id;
    assign wb_data  = sel_data;
`endif

endmodule

// File: doc/fp_wb_arbiter.md
# fp_wb_arbiter

Writeback-side consumer of the FP unit writeback protocol: collects `done`/`id`/`rd`/`fflags` from the FPU's internal result producers, grants one per cycle with a round-robin `ack`, and drives a single FP register-file writeback port. Also keeps the sticky fflags accumulator that feeds the fcsr, merging CSR writes and retiring-instruction flags without loss. Sits between the FPU execution units and the FP register file / CSR unit.

## Interface
- `NUM_UNITS`, 4, number of producing units (2..8)
- `FLEN`, 64, result width
- `ID_WIDTH`, 3, instruction id width
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `unit_done`  in  NUM_UNITS  unit i holds a valid result
- `unit_id`  in  NUM_UNITS x ID_WIDTH  id of unit i's result
- `unit_rd`  in  NUM_UNITS x FLEN  result data of unit i
- `unit_fflags`  in  NUM_UNITS x 5  exception flags of unit i (NV,DZ,OF,UF,NX)
- `unit_ack`  out  NUM_UNITS  one-hot grant; unit i's result consumed this cycle
- `wb_valid`  out  1  writeback to FP register file
- `wb_id`  out  ID_WIDTH  id being written back
- `wb_data`  out  FLEN  data being written back
- `csr_fflags_we`  in  1  CSR write to fflags this cycle
- `csr_fflags_wdata`  in  5  value written by CSR
- `fflags_acc`  out  5  current sticky fflags

## Operation
- Grant: among `unit_done`, pick first set bit scanning from `rr_ptr` upward modulo NUM_UNITS; assert that `unit_ack` bit combinationally same cycle. At most one ack per cycle; none if no `unit_done`.
- Unit holds `done`, `id`, `rd`, `fflags` stable until acked; drops `done` (or presents next result) the cycle after ack.
- `rr_ptr` (log2 NUM_UNITS bits, reset 0): on a grant to unit g, `rr_ptr <= (g+1) mod NUM_UNITS`; unchanged with no grant. Wrap-around: grant to unit NUM_UNITS-1 sets pointer 0.
- Writeback port never stalls: a grant is always accepted; `wb_id`/`wb_data` = granted unit's fields (see Configuration for timing).
- fflags accumulator, updated at the edge ending the grant cycle:
  - CSR write only: `fflags_acc <= csr_fflags_wdata`
  - grant only: `fflags_acc <= fflags_acc | unit_fflags[g]`
  - both same cycle: `fflags_acc <= csr_fflags_wdata | unit_fflags[g]` (retiring flags never lost)
  - neither: hold.
- Reset mid-operation: pending `unit_done` ignored during reset; acks, pointer, accumulator, output register cleared; arbitration resumes first cycle after `rst` low.

## Timing
- Reset values: `unit_ack` 0, `wb_valid` 0, `wb_id` 0, `wb_data` 0, `fflags_acc` 0, `rr_ptr` 0.
- `unit_ack` is combinational from `unit_done` and `rr_ptr`; forced 0 while `rst` high.
- Throughput: one result per cycle sustained; N units continuously done each receive ack every N cycles.
- Writeback latency from ack: 1 cycle with FP_WB_OUTPUT_REG_EN, 0 without.
- `fflags_acc` reflects a granted result's flags one cycle after ack in both builds.

## Configuration
- `FP_WB_OUTPUT_REG_EN` defined: `wb_valid`/`wb_id`/`wb_data` registered; appear the cycle after `unit_ack`; `wb_valid` low in cycles following no-grant cycles.
- Undefined: outputs combinational, `wb_valid` equals `|unit_ack` in the grant cycle, `wb_id`/`wb_data` muxed from granted unit (0 when no grant).

## Structure
- Shared package (`fpu_types`): `fflags_t` (5-bit struct), `FP_NUM_WB_UNITS` constant, writeback packet typedef {id, data}.
- One sub-module: `fp_rr_arbiter` (parameterized request vector + pointer in, one-hot grant and index out, combinational); pointer register lives in this block.

## Test plan
- Single unit: unit 2 done, id=5, rd=64'h3FF0_0000_0000_0000, fflags=5'b00001 -> ack[2] same cycle; wb_valid with id 5/data 1.0 next cycle (reg build); fflags_acc=5'b00001 after.
- Round robin: all 4 units hold done continuously from reset -> ack order 0,1,2,3,0,1 over six cycles; rr_ptr wraps 3->0.
- Pointer skip: rr_ptr=1, only units 0 and 3 done -> unit 3 acked, rr_ptr=0; next cycle unit 0 acked.
- Simultaneous CSR write: fflags_acc=5'b10000, csr write 5'b00010 with grant carrying 5'b00100 -> fflags_acc=5'b00110.
- Reset mid-stream: assert rst while units 0,1 done -> no ack, wb_valid 0, fflags_acc 0, rr_ptr 0; after release unit 0 acked first.
- Idle: no done for 10 cycles -> no ack, wb_valid 0, fflags_acc unchanged.
